// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_ctrl_pkg: shared state encoding and derived FFT sizing constants |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fft_ctrl_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_INIT  = 3'd1;
  localparam logic [2:0] ENC_RUN   = 3'd2;
  localparam logic [2:0] ENC_DRAIN = 3'd3;
  localparam logic [2:0] ENC_FIN   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_INIT  = ENC_INIT,
    ST_RUN   = ENC_RUN,
    ST_DRAIN = ENC_DRAIN,
    ST_FIN   = ENC_FIN
  } ctrl_state_t;

  // Butterflies per stage for a 2^awl-point transform.
  function automatic int n_bf(input int awl);
    return 1 << (awl - 1);
  endfunction

  function automatic int n_stage(input int awl);
    return awl;
  endfunction

  function automatic int stage_w(input int awl);
    return (awl > 2) ? $clog2(awl) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_valid_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_valid_delay: DEPTH-cycle valid shift register, async clear       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_valid_delay #(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic VALID_IN,
  output logic VALID_OUT
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= VALID_IN;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign VALID_OUT = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_stage_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_stage_controller: sequences one in-place radix-2 FFT frame       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fft_stage_controller
  import fft_ctrl_pkg::*;
#(
  parameter int AWL      = 5,
  parameter int PIPE_LAT = 4,
  parameter int SWL      = stage_w(AWL)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic           HOLD,
  output logic           BUSY,
  output logic           DONE,
  output logic           AG_RST,
  output logic           AG_EN,
  output logic           AG_LAY_EN,
  output logic           RD_EN,
  output logic           WR_EN,
  output logic [SWL-1:0] STAGE,
  output logic [AWL-2:0] BF_IDX
);

  localparam int N_BF    = n_bf(AWL);
  localparam int N_STAGE = n_stage(AWL);
  localparam int DCW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [AWL-2:0] BF_LAST    = (AWL-1)'(N_BF - 1);
  localparam logic [AWL-2:0] BF_ONE     = (AWL-1)'(1);
  localparam logic [SWL-1:0] STAGE_LAST = SWL'(N_STAGE - 1);
  localparam logic [SWL-1:0] STAGE_ONE  = SWL'(1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LAT - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  ctrl_state_t    r_state;
  logic           r_busy;
  logic           r_done;
  logic           r_ag_rst;
  logic           r_lay_en;
  logic [SWL-1:0] r_stage;
  logic [AWL-2:0] r_bf_idx;
  logic [DCW-1:0] r_drain_cnt;
  logic           w_issue;

  // Issue is the only path from an input straight to an output.
  assign w_issue = (r_state == ST_RUN) && !HOLD;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ag_rst    <= 1'b0;
      r_lay_en    <= 1'b0;
      r_stage     <= '0;
      r_bf_idx    <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_ag_rst <= 1'b0;
      r_lay_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state  <= ST_INIT;
            r_busy   <= 1'b1;
            r_ag_rst <= 1'b1;
            r_stage  <= '0;
            r_bf_idx <= '0;
          end
        end
        ST_INIT: begin
          r_state  <= ST_RUN;
          r_stage  <= '0;
          r_bf_idx <= '0;
        end
        ST_RUN: begin
          if (!HOLD) begin
            r_bf_idx <= r_bf_idx + BF_ONE;
            if (r_bf_idx == BF_LAST) begin
              r_state     <= ST_DRAIN;
              r_lay_en    <= 1'b1;
              r_drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // Last write-back of the stage lands in the final drain cycle.
          if (r_drain_cnt == DRAIN_LAST) begin
            if (r_stage == STAGE_LAST) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + STAGE_ONE;
              r_state <= ST_RUN;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_ONE;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  fft_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_wr_delay (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VALID_IN  (w_issue),
    .VALID_OUT (WR_EN)
  );

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign AG_RST    = r_ag_rst;
  assign AG_EN     = w_issue;
  assign RD_EN     = w_issue;
  assign AG_LAY_EN = r_lay_en;
  assign STAGE     = r_stage;
  assign BF_IDX    = r_bf_idx;

endmodule
`default_nettype wire

// File: doc/fft_stage_controller.md
Name: fft_stage_controller

Overview:
- Sequences one in-place radix-2 iterative FFT frame over a 2^AWL-point memory.
- Drives the butterfly address generator (EN, LAY_EN, sync active-high reset) and issues memory read/write enables.
- Handles the start/done handshake with the frame-level host.
- Inserts a pipeline drain between stages so stage s+1 never reads a location before stage s has written it.

Parameters:
- AWL, 5, data-memory address width; N = 2^AWL points, AWL stages, 2^(AWL-1) butterflies per stage (AWL >= 2).
- PIPE_LAT, 4, cycles from butterfly read-enable to its write-back (read latency + butterfly pipeline), >= 1.
- SWL, $clog2(AWL) (minimum 1), width of the STAGE output.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a frame; sampled only in IDLE.
- HOLD  in  1  stall request (memory port borrowed); freezes issue in RUN.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the frame completes.
- AG_RST  out  1  synchronous active-high reset to the address generator.
- AG_EN  out  1  address generator advance enable.
- AG_LAY_EN  out  1  address generator stage-rotate pulse.
- RD_EN  out  1  read the A/B pair at the current generator addresses.
- WR_EN  out  1  write back the butterfly result; equals RD_EN delayed exactly PIPE_LAT cycles.
- STAGE  out  SWL  current stage index, 0..AWL-1.
- BF_IDX  out  AWL-1  butterfly index within the stage, for twiddle lookup.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - All outputs 0; STAGE and BF_IDX 0.
  - WR_EN delay line cleared.
  - Reset mid-frame abandons the frame; the next frame must start with START.
- FSM states: IDLE, INIT, RUN, DRAIN, FIN.
- IDLE:
  - START=1 -> INIT on the next edge.
  - START=0 -> stay.
- INIT (1 cycle):
  - AG_RST=1, which forces generator addr=0 and lay=1.
  - Clear STAGE and BF_IDX.
  - -> RUN.
- RUN:
  - AG_EN = RD_EN = ~HOLD.
  - BF_IDX increments on each issued cycle.
  - When the issue with BF_IDX = 2^(AWL-1)-1 occurs -> DRAIN; BF_IDX wraps to 0.
  - HOLD=1: no issue, BF_IDX and the generator hold. HOLD is ignored in all other states.
- DRAIN (exactly PIPE_LAT cycles, counted by a drain counter):
  - AG_LAY_EN=1 in the first DRAIN cycle only. The generator address has already wrapped to 0 after the final EN of the stage.
  - On the last DRAIN cycle:
    - if STAGE = AWL-1 -> FIN;
    - else STAGE+1 and -> RUN.
- FIN (1 cycle):
  - DONE=1 -> IDLE.
  - The delay line is empty by construction.
- BUSY is registered: high in INIT/RUN/DRAIN/FIN, low in IDLE.
- Control outputs (AG_EN, RD_EN, AG_LAY_EN, AG_RST) are Moore/registered. Only the HOLD gating of AG_EN/RD_EN is combinational.
- Stage and rotate bookkeeping:
  - Total AG_LAY_EN pulses per frame = AWL, so the generator's lay returns to 1 at frame end.
  - AG_RST is still issued at every frame start.
- START while BUSY is ignored. START held high across FIN starts the next frame from IDLE on the following cycle.
- No-stall frame length, START edge to DONE: 1 + AWL*(2^(AWL-1) + PIPE_LAT) + 1 cycles after the START cycle.

Decomposition:
- Shared package fft_ctrl_pkg:
  - FSM state encoding localparams (IDLE, INIT, RUN, DRAIN, FIN);
  - derived constants N_BF = 2^(AWL-1) and N_STAGE = AWL.
- One sub-module, fft_valid_delay: PIPE_LAT-deep shift register with async active-low clear, used to generate WR_EN from RD_EN.
- The butterfly address generator is instantiated by the parent, not inside this block.

Test Plan:
1. AWL=3, PIPE_LAT=2, START pulse at cycle 0, HOLD=0:
   - AG_RST at c1;
   - RUN c2-5, c8-11, c14-17;
   - DRAIN c6-7, c12-13, c18-19;
   - DONE only at c20; BUSY high c1-c20.
2. Same run with the generator attached:
   - A/B sequence stage0 (0,1)(2,3)(4,5)(6,7), stage1 (0,2)(1,3)(4,6)(5,7), stage2 (0,4)(1,5)(2,6)(3,7);
   - exactly 3 AG_LAY_EN pulses;
   - WR_EN pattern equals RD_EN shifted by 2 cycles.
3. HOLD=1 for 3 cycles mid-stage-1 (at BF_IDX=2):
   - BF_IDX, generator addr and AG_EN frozen;
   - DONE delayed by exactly 3 cycles (c23);
   - no lost or duplicated read.
4. RST_N low for 1 cycle during stage 1 RUN:
   - all outputs 0 immediately, without waiting for an edge;
   - FSM in IDLE; no WR_EN afterwards;
   - a new START completes normally.
5. START asserted continuously:
   - back-to-back frames, each preceded by one AG_RST;
   - DONE pulses 21 cycles apart (AWL=3, PIPE_LAT=2);
   - START pulses during BUSY have no effect.
6. AWL=5, PIPE_LAT=4, one frame:
   - 16 issues per stage, 5 stages, 80 RD_EN and 80 WR_EN total;
   - DONE at cycle 102.
